system_readback: RTL and testbench

- Host-read counterpart to the system RAM writer: the controller writes block, target, status and nonce dwords into system RAM; this block reads them back out.
- On a host read request it fetches a contiguous range of 32-bit dwords from the system RAM read port and serialises each dword into bytes on the UART TX byte stream.
- Sits between the system RAM second port and the UART transmitter, in the clk_h domain.

---
 rtl/system_readback_if.sv | 28 ++
 rtl/system_readback.sv | 163 ++++++++++++++++
 tb/tb_system_readback.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/system_readback_if.sv
// Host-read bus bundle for system_readback: host request/status, system RAM read port
// and UART TX byte stream. The slave modport is the readback block's view.
interface system_readback_if #(
  parameter int ADDR_W = 6
);
  logic              host_break;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W:0]   rd_len;
  logic              busy;
  logic              rd_done;
  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_rd_addr;
  logic [31:0]       ram_rd_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport slave (
    input  host_break, rd_req, rd_addr, rd_len, ram_rd_data, tx_ready,
    output busy, rd_done, ram_rd_en, ram_rd_addr, tx_data, tx_valid
  );

  modport master (
    output host_break, rd_req, rd_addr, rd_len, ram_rd_data, tx_ready,
    input  busy, rd_done, ram_rd_en, ram_rd_addr, tx_data, tx_valid
  );
endinterface

// File: rtl/system_readback.sv
// Reads a range of dwords from system RAM and streams them little-endian as bytes to UART TX.
// Optional trailing XOR checksum byte when SYS_READBACK_CSUM_EN is defined.
module system_readback #(
  parameter int ADDR_W         = 6,
  parameter int RAM_RD_LATENCY = 2
) (
  input logic              clk_h,
  input logic              rst_n,
  system_readback_if.slave bus
);

`ifdef SYS_READBACK_CSUM_EN
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, NEXT, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, WAIT, SEND, NEXT} state_t;
`endif

  localparam logic [1:0] LAT_LAST = 2'(RAM_RD_LATENCY - 1);

  state_t            r_state;
  logic              r_busy;
  logic              r_rd_done;
  logic              r_ram_rd_en;
  logic              r_tx_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_remain;
  logic [1:0]        r_wait;
  logic [1:0]        r_byte;
  logic [31:0]       r_shift;
`ifdef SYS_READBACK_CSUM_EN
  logic [7:0]        r_csum;
`endif

  logic w_xfer;
  logic w_last;

  assign w_xfer = r_tx_valid & bus.tx_ready;
  assign w_last = (r_remain == (ADDR_W+1)'(1));

  // busy doubles as "transfer active"; it is already low in the final NEXT cycle
  always_ff @(posedge clk_h) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_rd_done   <= 1'b0;
      r_ram_rd_en <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_addr      <= '0;
      r_remain    <= '0;
      r_wait      <= '0;
      r_byte      <= '0;
      r_shift     <= '0;
`ifdef SYS_READBACK_CSUM_EN
      r_csum      <= '0;
`endif
    end else begin
      r_rd_done <= 1'b0;
      if (bus.host_break && r_busy) begin
        r_state     <= IDLE;
        r_busy      <= 1'b0;
        r_rd_done   <= 1'b1;
        r_ram_rd_en <= 1'b0;
        r_tx_valid  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.rd_req && !bus.host_break) begin
`ifdef SYS_READBACK_CSUM_EN
              r_csum <= '0;
`endif
              if (bus.rd_len != '0) begin
                r_addr      <= bus.rd_addr;
                r_remain    <= bus.rd_len;
                r_busy      <= 1'b1;
                r_ram_rd_en <= 1'b1;
                r_state     <= FETCH;
              end else begin
`ifdef SYS_READBACK_CSUM_EN
                r_shift    <= '0;
                r_busy     <= 1'b1;
                r_tx_valid <= 1'b1;
                r_state    <= CSUM;
`else
                r_rd_done  <= 1'b1;
`endif
              end
            end
          end
          FETCH: begin
            r_ram_rd_en <= 1'b0;
            r_wait      <= '0;
            r_state     <= WAIT;
          end
          WAIT: begin
            if (r_wait == LAT_LAST) begin
              r_shift    <= bus.ram_rd_data;
              r_byte     <= '0;
              r_tx_valid <= 1'b1;
              r_state    <= SEND;
            end else begin
              r_wait <= r_wait + 2'd1;
            end
          end
          SEND: begin
            if (w_xfer) begin
`ifdef SYS_READBACK_CSUM_EN
              r_csum <= r_csum ^ r_shift[7:0];
`endif
              r_shift <= {8'h00, r_shift[31:8]};
              r_byte  <= r_byte + 2'd1;
              if (r_byte == 2'd3) begin
                r_tx_valid <= 1'b0;
                r_state    <= NEXT;
`ifdef SYS_READBACK_CSUM_EN
`else
                if (w_last) begin
                  r_busy    <= 1'b0;
                  r_rd_done <= 1'b1;
                end
`endif
              end
            end
          end
          NEXT: begin
            r_remain <= r_remain - (ADDR_W+1)'(1);
            r_addr   <= r_addr + ADDR_W'(1);
            if (!w_last) begin
              r_ram_rd_en <= 1'b1;
              r_state     <= FETCH;
            end else begin
`ifdef SYS_READBACK_CSUM_EN
              r_shift    <= {24'h000000, r_csum};
              r_tx_valid <= 1'b1;
              r_state    <= CSUM;
`else
              r_state    <= IDLE;
`endif
            end
          end
`ifdef SYS_READBACK_CSUM_EN
          CSUM: begin
            if (w_xfer) begin
              r_tx_valid <= 1'b0;
              r_busy     <= 1'b0;
              r_rd_done  <= 1'b1;
              r_state    <= IDLE;
            end
          end
`endif
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.rd_done     = r_rd_done;
  assign bus.ram_rd_en   = r_ram_rd_en;
  assign bus.ram_rd_addr = r_addr;
  assign bus.tx_data     = r_shift[7:0];
  assign bus.tx_valid    = r_tx_valid;

endmodule

// File: tb/tb_system_readback.sv
// Directed self-checking bench for system_readback (RAM_RD_LATENCY=2) with a 2-stage RAM model
// and a negedge monitor logging transferred bytes, RAM fetch addresses and rd_done pulses.
module tb_system_readback;

  logic clk_h;
  logic rst_n;
  int   nChecks = 0;
  int   nErrors = 0;

  system_readback_if #(.ADDR_W(6)) bus();

  system_readback #(.ADDR_W(6), .RAM_RD_LATENCY(2)) dut (
    .clk_h (clk_h),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk_h = 1'b0;
  always #5 clk_h = ~clk_h;

  // RAM model: two-cycle read pipeline, poison value when not strobed
  logic [31:0] ram [64];
  logic [31:0] pipe0, pipe1;
  always @(posedge clk_h) begin
    pipe0 <= bus.ram_rd_en ? ram[bus.ram_rd_addr] : 32'hDEAD_BEEF;
    pipe1 <= pipe0;
  end
  assign bus.ram_rd_data = pipe1;

  logic [7:0] rxq [$];
  logic [7:0] expq [$];
  logic [5:0] addrq [$];
  int         doneCount;
  int         stallErr;
  logic       prevValid, prevReady;
  logic [7:0] prevData;

  always @(negedge clk_h) begin
    if (!rst_n) begin
      prevValid = 1'b0;
      prevReady = 1'b0;
      prevData  = 8'h00;
    end else begin
      if (bus.tx_valid && bus.tx_ready) rxq.push_back(bus.tx_data);
      if (bus.ram_rd_en) addrq.push_back(bus.ram_rd_addr);
      if (bus.rd_done) doneCount++;
      if (prevValid && !prevReady && (!bus.tx_valid || bus.tx_data !== prevData)) stallErr++;
      prevValid = bus.tx_valid;
      prevReady = bus.tx_ready;
      prevData  = bus.tx_data;
    end
  end

  task automatic tick();
    @(posedge clk_h);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] addr, input logic [6:0] len);
    bus.rd_addr = addr;
    bus.rd_len  = len;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
  endtask

  task automatic clearLog();
    rxq.delete();
    expq.delete();
    addrq.delete();
    doneCount = 0;
    stallErr  = 0;
  endtask

  task automatic expectDword(input logic [31:0] d);
    expq.push_back(d[7:0]);
    expq.push_back(d[15:8]);
    expq.push_back(d[23:16]);
    expq.push_back(d[31:24]);
  endtask

  task automatic finishExpected();
`ifdef SYS_READBACK_CSUM_EN
    logic [7:0] x = 8'h00;
    foreach (expq[i]) x ^= expq[i];
    expq.push_back(x);
`endif
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (bus.rd_done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done_seen"}, 32'(bus.rd_done), 32'd1);
    tick();
  endtask

  task automatic compareBytes(input string tag);
    checkOutput($sformatf("%s_count", tag), 32'(rxq.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < rxq.size(); i++)
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(rxq[i]), 32'(expq[i]));
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.host_break = 1'b0;
    bus.rd_req     = 1'b0;
    bus.rd_addr    = '0;
    bus.rd_len     = '0;
    bus.tx_ready   = 1'b1;
    for (int i = 0; i < 64; i++) ram[i] = 32'(i) * 32'h0101_0101;
    ram[5]     = 32'h1234_5678;
    ram[9]     = 32'hA5A5_0F0F;
    ram[6'h3e] = 32'h1122_3344;
    ram[6'h3f] = 32'h5566_7788;
    ram[6'h00] = 32'h99AA_BBCC;
    ram[6'h10] = 32'hCAFE_BABE;
    ram[6'h20] = 32'h0102_0304;
    ram[6'h21] = 32'hFF00_FF00;
    clearLog();
    tick(); tick(); tick();

    checkOutput("rst_busy",     32'(bus.busy),        32'd0);
    checkOutput("rst_rd_done",  32'(bus.rd_done),     32'd0);
    checkOutput("rst_ram_en",   32'(bus.ram_rd_en),   32'd0);
    checkOutput("rst_tx_valid", 32'(bus.tx_valid),    32'd0);
    checkOutput("rst_ram_addr", 32'(bus.ram_rd_addr), 32'd0);
    checkOutput("rst_tx_data",  32'(bus.tx_data),     32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single dword at address 5, latency and byte order");
    clearLog();
    expectDword(32'h1234_5678);
    finishExpected();
    applyStimulus(6'd5, 7'd1);
    checkOutput("t1_ram_en_c1",   32'(bus.ram_rd_en),   32'd1);
    checkOutput("t1_ram_addr_c1", 32'(bus.ram_rd_addr), 32'd5);
    checkOutput("t1_busy_c1",     32'(bus.busy),        32'd1);
    tick();
    checkOutput("t1_ram_en_c2",   32'(bus.ram_rd_en),   32'd0);
    tick();
    checkOutput("t1_valid_c3",    32'(bus.tx_valid),    32'd0);
    tick();
    checkOutput("t1_valid_c4",    32'(bus.tx_valid),    32'd1);
    checkOutput("t1_data_c4",     32'(bus.tx_data),     32'h78);
    tick();
    checkOutput("t1_data_c5",     32'(bus.tx_data),     32'h56);
    tick();
    checkOutput("t1_data_c6",     32'(bus.tx_data),     32'h34);
    tick();
    checkOutput("t1_data_c7",     32'(bus.tx_data),     32'h12);
    checkOutput("t1_done_c7",     32'(bus.rd_done),     32'd0);
    tick();
    checkOutput("t1_valid_c8",    32'(bus.tx_valid),    32'd0);
`ifdef SYS_READBACK_CSUM_EN
    checkOutput("t1_done_c8",     32'(bus.rd_done),     32'd0);
    tick();
    checkOutput("t1_csum_valid",  32'(bus.tx_valid),    32'd1);
    checkOutput("t1_csum_data",   32'(bus.tx_data),     32'h08);
    tick();
`endif
    checkOutput("t1_done_pulse",  32'(bus.rd_done),     32'd1);
    checkOutput("t1_busy_end",    32'(bus.busy),        32'd0);
    tick();
    checkOutput("t1_done_clear",  32'(bus.rd_done),     32'd0);
    compareBytes("t1");
    checkOutput("t1_done_count",  32'(doneCount),       32'd1);

    $display("[TB] three dwords wrapping 3e,3f,00 with an ignored rd_req while busy");
    clearLog();
    expectDword(32'h1122_3344);
    expectDword(32'h5566_7788);
    expectDword(32'h99AA_BBCC);
    finishExpected();
    applyStimulus(6'h3e, 7'd3);
    tick();
    bus.rd_addr = 6'h20;
    bus.rd_len  = 7'd5;
    bus.rd_req  = 1'b1;
    tick();
    bus.rd_req  = 1'b0;
    waitDone("t2", 200);
    checkOutput("t2_fetch_count", 32'(addrq.size()), 32'd3);
    if (addrq.size() == 3) begin
      checkOutput("t2_addr0", 32'(addrq[0]), 32'h3e);
      checkOutput("t2_addr1", 32'(addrq[1]), 32'h3f);
      checkOutput("t2_addr2", 32'(addrq[2]), 32'h00);
    end
    compareBytes("t2");
    checkOutput("t2_done_count", 32'(doneCount), 32'd1);

    $display("[TB] tx_ready high one cycle in three");
    clearLog();
    expectDword(32'hA5A5_0F0F);
    finishExpected();
    bus.tx_ready = 1'b0;
    applyStimulus(6'd9, 7'd1);
    for (int i = 0; i < 200 && bus.rd_done !== 1'b1; i++) begin
      bus.tx_ready = (i % 3 == 2);
      tick();
    end
    checkOutput("t3_done_seen", 32'(bus.rd_done), 32'd1);
    bus.tx_ready = 1'b1;
    tick();
    compareBytes("t3");
    checkOutput("t3_stall_stable", 32'(stallErr), 32'd0);

    $display("[TB] host_break after second byte, then a normal read");
    clearLog();
    expq.push_back(8'hBE);
    expq.push_back(8'hBA);
    expq.push_back(8'hFE);
    applyStimulus(6'h10, 7'd4);
    for (int n = 0; n < 100 && rxq.size() < 2; n++) tick();
    bus.host_break = 1'b1;
    tick();
    bus.host_break = 1'b0;
    checkOutput("t4_valid_off", 32'(bus.tx_valid),  32'd0);
    checkOutput("t4_busy_off",  32'(bus.busy),      32'd0);
    checkOutput("t4_done",      32'(bus.rd_done),   32'd1);
    checkOutput("t4_ram_en",    32'(bus.ram_rd_en), 32'd0);
    tick();
    checkOutput("t4_done_clear", 32'(bus.rd_done),  32'd0);
    tick(); tick();
    compareBytes("t4");
    checkOutput("t4_done_count", 32'(doneCount), 32'd1);
    clearLog();
    expectDword(32'h1234_5678);
    finishExpected();
    applyStimulus(6'd5, 7'd1);
    waitDone("t4b", 200);
    compareBytes("t4b");
    checkOutput("t4b_done_count", 32'(doneCount), 32'd1);

    $display("[TB] zero-length request");
    clearLog();
    finishExpected();
    applyStimulus(6'd7, 7'd0);
`ifdef SYS_READBACK_CSUM_EN
    checkOutput("t5_valid", 32'(bus.tx_valid), 32'd1);
    checkOutput("t5_data",  32'(bus.tx_data),  32'h00);
    waitDone("t5", 50);
`else
    checkOutput("t5_done",  32'(bus.rd_done),  32'd1);
    checkOutput("t5_busy",  32'(bus.busy),     32'd0);
    checkOutput("t5_valid", 32'(bus.tx_valid), 32'd0);
    tick();
    checkOutput("t5_done_clear", 32'(bus.rd_done), 32'd0);
    for (int n = 0; n < 6; n++) tick();
`endif
    compareBytes("t5");
    checkOutput("t5_done_count", 32'(doneCount), 32'd1);

`ifdef SYS_READBACK_CSUM_EN
    $display("[TB] checksum over two dwords");
    clearLog();
    expectDword(32'h0102_0304);
    expectDword(32'hFF00_FF00);
    expq.push_back(8'h04);
    applyStimulus(6'h20, 7'd2);
    waitDone("t6", 200);
    compareBytes("t6");
`endif

    $display("[TB] reset in the middle of a transfer");
    clearLog();
    applyStimulus(6'd5, 7'd1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    checkOutput("t7_valid", 32'(bus.tx_valid),  32'd0);
    checkOutput("t7_busy",  32'(bus.busy),      32'd0);
    checkOutput("t7_done",  32'(bus.rd_done),   32'd0);
    checkOutput("t7_data",  32'(bus.tx_data),   32'd0);
    rst_n = 1'b1;
    tick(); tick();
    checkOutput("t7_no_done", 32'(doneCount), 32'd0);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
